// File: rtl/pcie_dllp_tx.sv
// DLLP transmit generator: arbitrates NAK > ACK > PM and streams type, 3 content bytes, CRC-16.
// Latency: request sampled in IDLE at edge N -> grant pulse and first beat (tx_sop) in cycle N+1.
// Backpressure: beat index advances only on tx_valid && tx_ready; beat outputs hold while stalled.
// Optional SDP/END framing (L = 8 bytes instead of 6) is enabled by defining PCIE_DLLP_FRAMING_EN.
module pcie_dllp_tx #(
    parameter int LANE_BYTES = 2,
    parameter int SEQ_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    nak_req,
    input  logic [SEQ_W-1:0]        nak_seq,
    input  logic                    ack_req,
    input  logic [SEQ_W-1:0]        ack_seq,
    input  logic                    pm_req,
    input  logic [7:0]              pm_type,
    output logic                    nak_gnt,
    output logic                    ack_gnt,
    output logic                    pm_gnt,
    output logic [8*LANE_BYTES-1:0] tx_data,
    output logic [LANE_BYTES-1:0]   tx_k,
    output logic [LANE_BYTES-1:0]   tx_be,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    tx_sop,
    output logic                    tx_eop,
    output logic                    busy
);

`ifdef PCIE_DLLP_FRAMING_EN
    localparam int PKT_LEN = 8;
`else
    localparam int PKT_LEN = 6;
`endif
    localparam int         NUM_BEATS = (PKT_LEN + LANE_BYTES - 1) / LANE_BYTES;
    localparam logic [2:0] LAST_BEAT = 3'(NUM_BEATS - 1);

    localparam logic [7:0]  TYPE_ACK = 8'h00;
    localparam logic [7:0]  TYPE_NAK = 8'h10;
    localparam logic [7:0]  SYM_SDP  = 8'h5C;
    localparam logic [7:0]  SYM_END  = 8'hFD;
    localparam logic [15:0] CRC_POLY = 16'h100B;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    // Reject unsupported lane and sequence widths at elaboration.
    generate
        if (!(LANE_BYTES == 1 || LANE_BYTES == 2 || LANE_BYTES == 4)) begin : g_bad_lane
            $error("pcie_dllp_tx: LANE_BYTES must be 1, 2 or 4");
        end
        if (SEQ_W < 1 || SEQ_W > 12) begin : g_bad_seq
            $error("pcie_dllp_tx: SEQ_W must be in 1..12");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        arb_nak, arb_ack, arb_pm;
    logic        start;
    logic [11:0] nak_seq12, ack_seq12;
    logic [31:0] hdr_d, hdr_q;
    logic [15:0] crc_q;
    logic [63:0] pkt_bytes;
    logic [7:0]  pkt_k;
    logic [5:0]  idx;

    // CRC-16 over the 4 header bytes, MSB of byte 0 first, complemented for transmission.
    function automatic logic [15:0] crc16_hdr(input logic [31:0] hdr);
        logic [15:0] c;
        logic        fb;
        c = CRC_SEED;
        for (int b = 31; b >= 0; b--) begin
            fb = c[15] ^ hdr[b];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return ~c;
    endfunction

    // Zero-extend the sequence numbers to the 12-bit content field.
    always_comb begin
        nak_seq12              = '0;
        ack_seq12              = '0;
        nak_seq12[SEQ_W-1:0]   = nak_seq;
        ack_seq12[SEQ_W-1:0]   = ack_seq;
    end

    // Next-state, priority arbitration and beat counter; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        arb_nak = 1'b0;
        arb_ack = 1'b0;
        arb_pm  = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = 3'd0;
                if (nak_req) begin
                    arb_nak = 1'b1;
                end else if (ack_req) begin
                    arb_ack = 1'b1;
                end else if (pm_req) begin
                    arb_pm = 1'b1;
                end
                if (nak_req || ack_req || pm_req) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 3'd0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end
        endcase
    end

    assign start = arb_nak || arb_ack || arb_pm;

    // Header of the arbitration winner: type byte first, then the three content bytes.
    always_comb begin
        hdr_d = '0;
        if (arb_nak) begin
            hdr_d = {TYPE_NAK, 8'h00, 4'h0, nak_seq12[11:8], nak_seq12[7:0]};
        end else if (arb_ack) begin
            hdr_d = {TYPE_ACK, 8'h00, 4'h0, ack_seq12[11:8], ack_seq12[7:0]};
        end else if (arb_pm) begin
            hdr_d = {pm_type, 24'h000000};
        end
    end

    // FSM state and beat index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Latch the winning header and its CRC when the packet starts; hold them for the whole packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_q <= '0;
            crc_q <= '0;
        end else if (start) begin
            hdr_q <= hdr_d;
            crc_q <= crc16_hdr(hdr_d);
        end
    end

    // One-cycle grant pulses, coincident with the first beat of the granted packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nak_gnt <= 1'b0;
            ack_gnt <= 1'b0;
            pm_gnt  <= 1'b0;
        end else begin
            nak_gnt <= arb_nak;
            ack_gnt <= arb_ack;
            pm_gnt  <= arb_pm;
        end
    end

    // Lay the packet out as a byte stream; byte j sits on bits [8j+7:8j], byte 0 sent first.
    always_comb begin
        pkt_bytes = '0;
        pkt_k     = '0;
`ifdef PCIE_DLLP_FRAMING_EN
        pkt_bytes = {SYM_END, crc_q[7:0], crc_q[15:8],
                     hdr_q[7:0], hdr_q[15:8], hdr_q[23:16], hdr_q[31:24], SYM_SDP};
        pkt_k     = 8'b1000_0001;
`else
        pkt_bytes = {16'h0000, crc_q[7:0], crc_q[15:8],
                     hdr_q[7:0], hdr_q[15:8], hdr_q[23:16], hdr_q[31:24]};
`endif
    end

    // Map the current beat onto the lanes; lanes past the packet end carry 0 with tx_be low.
    always_comb begin
        tx_data = '0;
        tx_k    = '0;
        tx_be   = '0;
        idx     = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            idx = {3'b000, beat_q} * 6'(LANE_BYTES) + 6'(i);
            if (state_q == SEND && idx < 6'(PKT_LEN)) begin
                tx_data[8*i +: 8] = pkt_bytes[{idx[2:0], 3'b000} +: 8];
                tx_k[i]           = pkt_k[idx[2:0]];
                tx_be[i]          = 1'b1;
            end
        end
    end

    // Beat qualifiers derive from registered state only, so they drop with reset and hold under stall.
    assign tx_valid = (state_q == SEND);
    assign tx_sop   = tx_valid && (beat_q == 3'd0);
    assign tx_eop   = tx_valid && (beat_q == LAST_BEAT);
    assign busy     = (state_q != IDLE);

endmodule
